// File: rtl/mouse_pos_accum.sv
// mouse_pos_accum: per-channel relative mouse delta accumulator with clamp/wrap, recentre and spring-return decay
module mouse_pos_accum #(
  parameter int CHANNELS  = 2,
  parameter int IN_W      = 9,
  parameter int POS_W     = 10,
  parameter int OUT_W     = 8,
  parameter int SHIFT     = 1,
  parameter int SATURATE  = 1,
  parameter int IDLE_CYC  = 0,
  parameter int DECAY_DIV = 4096,
  localparam int IDX_W    = CHANNELS > 1 ? $clog2(CHANNELS) : 1
) (
  input  logic                      clk_sys,
  input  logic                      reset_n,
  input  logic                      mouse_strobe,
  input  logic [IDX_W-1:0]          mouse_idx,
  input  logic [IN_W-1:0]           mouse_x,
  input  logic [IN_W-1:0]           mouse_y,
  input  logic [7:0]                mouse_flags,
  input  logic [CHANNELS-1:0]       recentre,
  output logic [CHANNELS*POS_W-1:0] pos_x,
  output logic [CHANNELS*POS_W-1:0] pos_y,
  output logic [CHANNELS*OUT_W-1:0] an_x,
  output logic [CHANNELS*OUT_W-1:0] an_y,
  output logic [CHANNELS*3-1:0]     btns,
  output logic [CHANNELS-1:0]       moved
);
  localparam int PW = DECAY_DIV > 1 ? $clog2(DECAY_DIV) : 1;
  localparam int IW = IDLE_CYC > 0 ? $clog2(IDLE_CYC + 1) : 1;
  localparam logic signed [POS_W:0] HI = (POS_W+1)'(2**(OUT_W+SHIFT-1) - 1);
  localparam logic signed [POS_W:0] LO = (POS_W+1)'(-(2**(OUT_W+SHIFT-1)));
  typedef enum logic {TRACK, DECAY} state_t;
  logic [PW-1:0] pre;
  logic tick;
  logic unused;
  assign unused = ^mouse_flags[7:3];
  assign tick = pre == PW'(DECAY_DIV - 1);
  always_ff @(posedge clk_sys)
    if (!reset_n) pre <= '0;
    else pre <= tick ? '0 : pre + 1'b1;
  function automatic logic [POS_W-1:0] acc(input logic [POS_W-1:0] p, input logic [IN_W-1:0] d);
    logic signed [POS_W:0] s;
    s = $signed({p[POS_W-1], p}) + $signed({{(POS_W+1-IN_W){d[IN_W-1]}}, d});
    return SATURATE != 0 ? (s > HI ? HI[POS_W-1:0] : s < LO ? LO[POS_W-1:0] : s[POS_W-1:0]) : s[POS_W-1:0];
  endfunction
  function automatic logic [POS_W-1:0] toward_zero(input logic [POS_W-1:0] p);
    return p == '0 ? p : p[POS_W-1] ? p + 1'b1 : p - 1'b1;
  endfunction
  for (genvar n = 0; n < CHANNELS; n++) begin : g_ch
    logic [POS_W-1:0] px, py, nx, ny;
    logic [OUT_W-1:0] ax, ay;
    logic [2:0] b;
    logic mv, hit, clr, step_en;
    logic [IW-1:0] idle, idle_n;
    state_t st, st_n;
    assign hit = mouse_strobe && mouse_idx == IDX_W'(n);
    assign clr = hit || recentre[n] || IDLE_CYC == 0;
    // recentre beats a same-cycle strobe, which in turn beats a decay tick
    always_comb begin
      st_n = clr ? TRACK : (st == TRACK && idle == IW'(IDLE_CYC)) ? DECAY : st;
      idle_n = clr ? '0 : (st == TRACK && idle != IW'(IDLE_CYC)) ? idle + 1'b1 : idle;
      step_en = !clr && st == DECAY && tick;
      nx = recentre[n] ? '0 : hit ? acc(px, mouse_x) : step_en ? toward_zero(px) : px;
      ny = recentre[n] ? '0 : hit ? acc(py, mouse_y) : step_en ? toward_zero(py) : py;
    end
    always_ff @(posedge clk_sys)
      if (!reset_n) begin
        px <= '0;
        py <= '0;
        ax <= OUT_W'(2**(OUT_W-1));
        ay <= OUT_W'(2**(OUT_W-1));
        b <= '0;
        mv <= 1'b0;
        idle <= '0;
        st <= TRACK;
      end else begin
        px <= nx;
        py <= ny;
        ax <= {~px[OUT_W+SHIFT-1], px[OUT_W+SHIFT-2:SHIFT]};
        ay <= {~py[OUT_W+SHIFT-1], py[OUT_W+SHIFT-2:SHIFT]};
        b <= hit ? mouse_flags[2:0] : b;
        mv <= nx != px || ny != py;
        idle <= idle_n;
        st <= st_n;
      end
    assign pos_x[n*POS_W +: POS_W] = px;
    assign pos_y[n*POS_W +: POS_W] = py;
    assign an_x[n*OUT_W +: OUT_W] = ax;
    assign an_y[n*OUT_W +: OUT_W] = ay;
    assign btns[n*3 +: 3] = b;
    assign moved[n] = mv;
  end
endmodule
